// File: rtl/mpu_bus_arbiter_if.sv
// Bus bundle between N mpu-style masters, the arbiter and the shared memory port.
interface mpu_bus_arbiter_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8
);
    logic [N_MASTERS-1:0]        REQ;
    logic [N_MASTERS-1:0]        M_R_W;
    logic [N_MASTERS*ADDR_W-1:0] M_ADDR;
    logic [N_MASTERS*DATA_W-1:0] M_WDATA;
    logic [N_MASTERS-1:0]        RDY;
    logic [DATA_W-1:0]           RDATA;
    logic                        MEM_EN;
    logic                        MEM_R_W;
    logic [ADDR_W-1:0]           MEM_ADDR;
    logic [DATA_W-1:0]           MEM_WDATA;
    logic [DATA_W-1:0]           MEM_RDATA;

    modport slave (
        input  REQ, M_R_W, M_ADDR, M_WDATA, MEM_RDATA,
        output RDY, RDATA, MEM_EN, MEM_R_W, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output REQ, M_R_W, M_ADDR, M_WDATA, MEM_RDATA,
        input  RDY, RDATA, MEM_EN, MEM_R_W, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mpu_bus_arbiter.sv
// Shares one memory port between N mpu bus masters; losers are stalled via RDY.
module mpu_bus_arbiter #(
    parameter int unsigned N_MASTERS   = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RR_MODE     = 0
) (
    input  logic             CLK,
    input  logic             RES,
    mpu_bus_arbiter_if.slave bus
);
    localparam int unsigned GNT_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [GNT_W-1:0]       gnt_q, gnt_d;
    logic [GNT_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_r_w_q, mem_r_w_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [N_MASTERS-1:0]   ack_q, ack_d;

    logic                   win_found;
    logic [GNT_W-1:0]       win_idx;
    int unsigned            idx;

    // Winner search: index order (fixed) or rotated to start after last grant (round-robin).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                idx = (32'(last_q) + 32'd1 + k) % N_MASTERS;
            end else begin
                idx = k;
            end
            if (!win_found && bus.REQ[GNT_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = GNT_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_r_w_d   = mem_r_w_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d       = win_idx;
                    last_d      = win_idx;
                    mem_r_w_d   = bus.M_R_W[win_idx];
                    mem_addr_d  = bus.M_ADDR[32'(win_idx) * ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.M_WDATA[32'(win_idx) * DATA_W +: DATA_W];
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    mem_en_d    = 1'b1;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (mem_r_w_q) begin
                        rdata_d = bus.MEM_RDATA;
                    end
                    ack_d[gnt_q] = 1'b1;
                    mem_en_d     = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any access in flight without an ack.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            last_q      <= GNT_W'(N_MASTERS - 1);
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_r_w_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_r_w_q   <= mem_r_w_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
        end
    end

    // Idle masters are never stalled; a requester is released only by its ack cycle.
    assign bus.RDY       = ~bus.REQ | ack_q;
    assign bus.RDATA     = rdata_q;
    assign bus.MEM_EN    = mem_en_q;
    assign bus.MEM_R_W   = mem_r_w_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;
endmodule

// File: tb/tb_mpu_bus_arbiter.sv
// Bench for mpu_bus_arbiter: two instances (fixed/no-wait, round-robin/two-wait) against a transaction-level model.
module tb_mpu_bus_arbiter;
    localparam int unsigned N     = 3;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned WAIT0 = 0;
    localparam int unsigned WAIT1 = 2;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            res      [2];
    logic [N-1:0]    req      [2];
    logic [N-1:0]    m_rw     [2];
    logic [N*AW-1:0] m_addr   [2];
    logic [N*DW-1:0] m_wd     [2];
    logic [N-1:0]    rdy      [2];
    logic [DW-1:0]   rdata    [2];
    logic            mem_en   [2];
    logic            mem_rw   [2];
    logic [AW-1:0]   mem_addr [2];
    logic [DW-1:0]   mem_wd   [2];

    int              n_cmp = 0;
    int              n_err = 0;
    op_t             ops     [N][4];
    int              cnt_ops [N];
    int              last_m  [2];
    logic [DW-1:0]   rdata_m [2];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h83;
    endfunction

    mpu_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
    mpu_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus0.REQ       = req[0];
    assign bus0.M_R_W     = m_rw[0];
    assign bus0.M_ADDR    = m_addr[0];
    assign bus0.M_WDATA   = m_wd[0];
    assign bus0.MEM_RDATA = bus0.MEM_EN ? mem_fn(bus0.MEM_ADDR) : ~mem_fn(bus0.MEM_ADDR);
    assign rdy[0]      = bus0.RDY;
    assign rdata[0]    = bus0.RDATA;
    assign mem_en[0]   = bus0.MEM_EN;
    assign mem_rw[0]   = bus0.MEM_R_W;
    assign mem_addr[0] = bus0.MEM_ADDR;
    assign mem_wd[0]   = bus0.MEM_WDATA;

    assign bus1.REQ       = req[1];
    assign bus1.M_R_W     = m_rw[1];
    assign bus1.M_ADDR    = m_addr[1];
    assign bus1.M_WDATA   = m_wd[1];
    assign bus1.MEM_RDATA = bus1.MEM_EN ? mem_fn(bus1.MEM_ADDR) : ~mem_fn(bus1.MEM_ADDR);
    assign rdy[1]      = bus1.RDY;
    assign rdata[1]    = bus1.RDATA;
    assign mem_en[1]   = bus1.MEM_EN;
    assign mem_rw[1]   = bus1.MEM_R_W;
    assign mem_addr[1] = bus1.MEM_ADDR;
    assign mem_wd[1]   = bus1.MEM_WDATA;

    mpu_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT0), .RR_MODE(0))
        u_dut0 (.CLK(clk), .RES(res[0]), .bus(bus0.slave));
    mpu_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT1), .RR_MODE(1))
        u_dut1 (.CLK(clk), .RES(res[1]), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        op_t o;
        o.rw = rw;
        o.a  = a;
        o.wd = wd;
        return o;
    endfunction

    task automatic drive(input int d, input int i, input op_t op);
        m_rw[d][i]           = op.rw;
        m_addr[d][i*AW +: AW] = op.a;
        m_wd[d][i*DW +: DW]   = op.wd;
    endtask

    task automatic rand_ops();
        int any;
        any = 0;
        for (int i = 0; i < N; i++) begin
            cnt_ops[i] = $urandom_range(0, 3);
            any += cnt_ops[i];
            for (int k = 0; k < 4; k++)
                ops[i][k] = mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
        end
        if (any == 0) cnt_ops[$urandom_range(0, N-1)] = 1;
    endtask

    // Model: grant order from the arbitration rule, then fixed W+3 cycle slots per access.
    task automatic run_batch(input int d);
        int  w, per, n, last, g;
        int  rem   [N];
        int  pos   [N];
        int  order [N*4];
        int  kidx  [N*4];
        op_t op;
        w    = (d == 0) ? WAIT0 : WAIT1;
        per  = w + 3;
        n    = 0;
        last = last_m[d];
        for (int i = 0; i < N; i++) begin
            rem[i] = cnt_ops[i];
            pos[i] = 0;
        end
        for (int s = 0; s < N*4; s++) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (d == 1) ? (last + k) % N : k - 1;
                if (g < 0 && rem[i] > 0) g = i;
            end
            if (g >= 0) begin
                order[n] = g;
                kidx[n]  = cnt_ops[g] - rem[g];
                rem[g]--;
                last = g;
                n++;
            end
        end
        last_m[d] = last;

        for (int i = 0; i < N; i++) begin
            req[d][i] = (cnt_ops[i] > 0);
            if (cnt_ops[i] > 0) drive(d, i, ops[i][0]);
        end

        for (int c = 1; c <= n*per; c++) begin
            int           j, p;
            logic [N-1:0] exp_rdy;
            tick();
            j  = (c - 1) / per;
            p  = (c - 1) % per;
            g  = order[j];
            op = ops[g][kidx[j]];
            chk("mem_en", 32'(mem_en[d]), 32'(p <= w));
            if (p <= w) begin
                chk("mem_addr", 32'(mem_addr[d]), 32'(op.a));
                chk("mem_r_w", 32'(mem_rw[d]), 32'(op.rw));
                if (!op.rw) chk("mem_wdata", 32'(mem_wd[d]), 32'(op.wd));
            end
            exp_rdy = ~req[d];
            if (p == w + 1) begin
                exp_rdy[g] = 1'b1;
                if (op.rw) rdata_m[d] = mem_fn(op.a);
            end
            chk("rdy", 32'(rdy[d]), 32'(exp_rdy));
            chk("rdata", 32'(rdata[d]), 32'(rdata_m[d]));
            if (p == 0) drive(d, g, mk(~op.rw, ~op.a, ~op.wd));
            if (p == w + 1) begin
                pos[g]++;
                if (pos[g] >= cnt_ops[g]) req[d][g] = 1'b0;
                else drive(d, g, ops[g][pos[g]]);
            end
        end
        for (int i = 0; i < N; i++) cnt_ops[i] = 0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            res[d]     = 1'b1;
            req[d]     = '0;
            m_rw[d]    = '0;
            m_addr[d]  = '0;
            m_wd[d]    = '0;
            last_m[d]  = N - 1;
            rdata_m[d] = '0;
        end
        for (int i = 0; i < N; i++) cnt_ops[i] = 0;

        // Reset state, with requests present on instance 0 while reset is held.
        tick();
        tick();
        req[0] = 3'b101;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_en", 32'(mem_en[d]), 32'd0);
            chk("rst_mem_r_w", 32'(mem_rw[d]), 32'd1);
            chk("rst_mem_addr", 32'(mem_addr[d]), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wd[d]), 32'd0);
            chk("rst_rdata", 32'(rdata[d]), 32'd0);
        end
        chk("rst_rdy0", 32'(rdy[0]), 32'h2);
        chk("rst_rdy1", 32'(rdy[1]), 32'h7);
        req[0] = '0;
        res[0] = 1'b0;
        res[1] = 1'b0;
        tick();
        chk("idle_no_req", 32'(mem_en[0]), 32'd0);

        // Single read, no wait states.
        ops[0][0] = mk(1'b1, 16'h1234, 8'h00);
        cnt_ops[0] = 1;
        run_batch(0);
        chk("t1_rdata", 32'(rdata[0]), 32'hA5);

        // Read then write: write must not disturb RDATA.
        ops[0][0] = mk(1'b1, 16'h00F4, 8'h00);
        ops[0][1] = mk(1'b0, 16'h0200, 8'h5A);
        cnt_ops[0] = 2;
        run_batch(0);
        chk("t5_rdata_hold", 32'(rdata[0]), 32'h77);

        // Fixed priority: master 0 held for three accesses starves master 1.
        rand_ops();
        cnt_ops[0] = 3;
        cnt_ops[1] = 1;
        cnt_ops[2] = 0;
        run_batch(0);

        repeat (12) begin
            rand_ops();
            run_batch(0);
        end

        // Round-robin from reset: 0,1,0,1.
        rand_ops();
        cnt_ops[0] = 2;
        cnt_ops[1] = 2;
        cnt_ops[2] = 0;
        run_batch(1);

        // Single read with wait states.
        ops[0][0] = mk(1'b1, 16'hBEEF, 8'h00);
        cnt_ops[0] = 1;
        run_batch(1);

        // REQ dropped mid-access: access completes, ack masked.
        drive(1, 2, mk(1'b1, 16'h4321, 8'h00));
        req[1] = 3'b100;
        tick();
        chk("drop_mem_en", 32'(mem_en[1]), 32'd1);
        chk("drop_mem_addr", 32'(mem_addr[1]), 32'h4321);
        req[1] = '0;
        for (int c = 1; c <= WAIT1 + 2; c++) begin
            tick();
            chk("drop_mem_en_run", 32'(mem_en[1]), 32'(c <= WAIT1));
            chk("drop_rdy", 32'(rdy[1]), 32'h7);
            if (c == WAIT1 + 1) rdata_m[1] = mem_fn(16'h4321);
            chk("drop_rdata", 32'(rdata[1]), 32'(rdata_m[1]));
        end
        last_m[1] = 2;

        // Reset mid-access: no ack, outputs back to reset values, fresh restart.
        drive(1, 1, mk(1'b1, 16'h0F0F, 8'h00));
        req[1] = 3'b010;
        tick();
        tick();
        chk("abort_pre_en", 32'(mem_en[1]), 32'd1);
        res[1] = 1'b1;
        tick();
        chk("abort_mem_en", 32'(mem_en[1]), 32'd0);
        chk("abort_rdy", 32'(rdy[1]), 32'h5);
        chk("abort_rdata", 32'(rdata[1]), 32'd0);
        res[1] = 1'b0;
        rdata_m[1] = '0;
        last_m[1]  = N - 1;
        ops[1][0] = mk(1'b1, 16'h0F0F, 8'h00);
        cnt_ops[1] = 1;
        run_batch(1);

        repeat (12) begin
            rand_ops();
            run_batch(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
